main_input_join: RTL



---
 rtl/main_input_join_if.sv | 40 ++++
 rtl/main_input_join.sv | 99 +++++++++
 2 files changed

// File: rtl/main_input_join_if.sv
// Handshake bundle for main_input_join: four independent input lanes plus
// the aligned output bundle that feeds main's shared ivalid/iready.
interface main_input_join_if #(
  parameter int unsigned STREAMW = 32
);
  logic [STREAMW-1:0] u_stream;
  logic [STREAMW-1:0] v_stream;
  logic [STREAMW-1:0] x_stream;
  logic [STREAMW-1:0] y_stream;
  logic               u_ivalid;
  logic               v_ivalid;
  logic               x_ivalid;
  logic               y_ivalid;
  logic               u_iready;
  logic               v_iready;
  logic               x_iready;
  logic               y_iready;
  logic [STREAMW-1:0] u_out;
  logic [STREAMW-1:0] v_out;
  logic [STREAMW-1:0] x_out;
  logic [STREAMW-1:0] y_out;
  logic               ovalid;
  logic               oready;

  modport master (
    output u_stream, v_stream, x_stream, y_stream,
    output u_ivalid, v_ivalid, x_ivalid, y_ivalid,
    input  u_iready, v_iready, x_iready, y_iready,
    input  u_out, v_out, x_out, y_out, ovalid,
    output oready
  );

  modport slave (
    input  u_stream, v_stream, x_stream, y_stream,
    input  u_ivalid, v_ivalid, x_ivalid, y_ivalid,
    output u_iready, v_iready, x_iready, y_iready,
    output u_out, v_out, x_out, y_out, ovalid,
    input  oready
  );
endinterface

// File: rtl/main_input_join.sv
// Four-lane FWFT input join: releases an aligned u/v/x/y bundle only when all
// lanes hold data. Optional MAIN_INPUT_JOIN_STATS_EN adds a popped-bundle counter.
module main_input_join #(
  parameter int unsigned STREAMW = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  main_input_join_if.slave     bus
`ifdef MAIN_INPUT_JOIN_STATS_EN
  ,
  output logic [31:0]          beat_count
`endif
);

  localparam int unsigned LANES = 4;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  logic [LANES-1:0]   lane_valid;
  logic [LANES-1:0]   lane_ready;
  logic [LANES-1:0]   lane_nonempty;
  logic [LANES-1:0]   lane_push;
  logic [STREAMW-1:0] lane_din  [LANES];
  logic [STREAMW-1:0] lane_head [LANES];
  logic               bundle_valid;
  logic               bundle_pop;

  assign lane_valid  = {bus.y_ivalid, bus.x_ivalid, bus.v_ivalid, bus.u_ivalid};
  assign lane_din[0] = bus.u_stream;
  assign lane_din[1] = bus.v_stream;
  assign lane_din[2] = bus.x_stream;
  assign lane_din[3] = bus.y_stream;

  // Ready and valid decode only registered counts, so oready never reaches iready.
  assign bundle_valid = &lane_nonempty;
  assign bundle_pop   = bundle_valid & bus.oready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [STREAMW-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    assign lane_ready[k]    = (count != CW'(DEPTH));
    assign lane_nonempty[k] = (count != '0);
    assign lane_push[k]     = lane_valid[k] & lane_ready[k];
    assign lane_head[k]     = mem[rd_ptr];

    // Storage is never cleared; stale words are unreachable once pointers reset.
    always_ff @(posedge clk) begin
      if (lane_push[k]) begin
        mem[wr_ptr] <= lane_din[k];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (lane_push[k]) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (bundle_pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (lane_push[k] && !bundle_pop) begin
          count <= count + CW'(1);
        end else if (!lane_push[k] && bundle_pop) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  assign bus.u_iready = lane_ready[0];
  assign bus.v_iready = lane_ready[1];
  assign bus.x_iready = lane_ready[2];
  assign bus.y_iready = lane_ready[3];

  assign bus.ovalid = bundle_valid;
  assign bus.u_out  = bundle_valid ? lane_head[0] : '0;
  assign bus.v_out  = bundle_valid ? lane_head[1] : '0;
  assign bus.x_out  = bundle_valid ? lane_head[2] : '0;
  assign bus.y_out  = bundle_valid ? lane_head[3] : '0;

`ifdef MAIN_INPUT_JOIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count <= '0;
    end else if (bundle_pop) begin
      beat_count <= beat_count + 32'(1);
    end
  end
`endif

endmodule
